// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store unit controller between a CPU and a single-port,
// word-wide memory with combinational read and clocked write.
//
// A request is accepted only in IDLE. Byte and half accesses are little-endian
// lanes of a 32-bit word:
//   - loads extract the lane and sign/zero-extend it;
//   - sub-word stores do a read-modify-write (IDLE->RD->WR->DONE);
//   - word stores write directly (IDLE->WR->DONE).
// Misaligned or illegal requests go straight to DONE with err set. They never
// touch memory, m_addr or rdata.
//
// Ports:
//   clk      clock, rising edge
//   clrn     asynchronous active-low reset
//   req      access request (sampled in IDLE only)
//   wr       1 = store, 0 = load
//   size     00 byte, 01 half, 10 word, 11 illegal
//   sext     sign-extend sub-word loads
//   addr     CPU byte address
//   wdata    store data (low bits used for sub-word stores)
//   busy     0 only in IDLE
//   done     one-cycle completion pulse
//   err      error flag, valid with done
//   rdata    last load result
//   m_addr   word-aligned memory address
//   m_wdata  memory write data (merged word)
//   m_we     memory write enable (WR state only)
//   m_rdata  memory read data, combinational from m_addr
// -----------------------------------------------------------------------------
module lsu_ctrl (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_we,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state, state_nxt;

    // Request fields captured at accept time.
    logic        wr_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] maddr_q;

    // Memory word captured on the RD exit edge; base for the store merge.
    logic [31:0] word_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        bad_req;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [31:0] merged;

    assign accept = (state == IDLE) && req;

    // Classify the live request. size=11 is illegal; half/word accesses must
    // be naturally aligned.
    always_comb begin
        bad_req = 1'b0;
        case (size)
            SZ_HALF: bad_req = addr[0];
            SZ_WORD: bad_req = (addr[1:0] != 2'b00);
            SZ_BYTE: bad_req = 1'b0;
            default: bad_req = 1'b1;
        endcase
    end

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad_req)
                        state_nxt = DONE;
                    else if (wr && (size == SZ_WORD))
                        state_nxt = WR;
                    else
                        state_nxt = RD;   // loads and sub-word stores read first
                end
            end
            RD:      state_nxt = wr_q ? WR : DONE;
            WR:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: only control and small data registers exist here; each is reset so
    // every output reads 0 during reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            lane_q  <= 2'b00;
            wdata_q <= '0;
            err_q   <= 1'b0;
            maddr_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                wr_q    <= wr;
                size_q  <= size;
                sext_q  <= sext;
                lane_q  <= addr[1:0];
                wdata_q <= wdata;
                err_q   <= bad_req;
                // Rejected requests leave the memory address untouched.
                if (!bad_req)
                    maddr_q <= {addr[31:2], 2'b00};
            end
            if (state == RD) begin
                word_q <= m_rdata;
                if (!wr_q)
                    rdata_q <= ld_val;
            end
        end
    end

    // Load lane extraction straight from the memory bus during RD.
    always_comb begin
        ld_byte = m_rdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? m_rdata[31:16] : m_rdata[15:0];
        case (size_q)
            SZ_BYTE: ld_val = {{24{sext_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_val = {{16{sext_q & ld_half[15]}}, ld_half};
            default: ld_val = m_rdata;     // word loads ignore sext
        endcase
    end

    // Store merge: overwrite only the addressed lane of the captured word.
    always_comb begin
        merged = word_q;
        case (size_q)
            SZ_BYTE: merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: begin
                if (lane_q[1])
                    merged[31:16] = wdata_q[15:0];
                else
                    merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    // m_we is decoded from the state register so an asynchronous reset in WR
    // removes the write enable immediately.
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = (state == DONE) && err_q;
    assign m_we    = (state == WR);
    assign m_addr  = maddr_q;
    assign m_wdata = merged;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- scoreboard bench for lsu_ctrl.
//
// The stimulus process pushes the hand-computed response of each request into
// a queue. A monitor, sampling on the falling edge, pops one entry on every
// done pulse. It then compares err, latency, write-enable behaviour and rdata.
// A 32-word memory model sits behind the DUT: combinational read, clocked write.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        bit          err;
        int          lat;      // cycle of done, counting the accept-edge cycle as 1
        int          we_cnt;   // expected number of m_we cycles
        int          we_cyc;   // cycle in which m_we is expected
        logic [31:0] maddr;
        logic [31:0] mwdata;
        bit          chk_rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] mem [32];

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk     (clk),
        .clrn    (clrn),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .sext    (sext),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_we    (m_we),
        .m_rdata (m_rdata)
    );

    // Memory model.
    assign m_rdata = mem[m_addr[6:2]];
    always @(posedge clk) begin
        if (m_we)
            mem[m_addr[6:2]] <= m_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input bit e, input int lat,
                                input int we_cnt, input int we_cyc,
                                input logic [31:0] ma, input logic [31:0] mw,
                                input bit chk_rd, input logic [31:0] rd);
        exp_t x;
        x.tag = tag; x.err = e; x.lat = lat; x.we_cnt = we_cnt; x.we_cyc = we_cyc;
        x.maddr = ma; x.mwdata = mw; x.chk_rd = chk_rd; x.rdata = rd;
        return x;
    endfunction

    // Monitor.
    initial begin
        int   cnt = 0;
        int   we_cnt = 0;
        int   we_cyc = 0;
        logic [31:0] we_addr = '0;
        logic [31:0] we_data = '0;
        logic prev_busy = 1'b0;
        exp_t x;
        forever begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                cnt = 1; we_cnt = 0; we_cyc = 0;
            end else if (busy) begin
                cnt++;
            end
            if (m_we) begin
                we_cnt++; we_cyc = cnt; we_addr = m_addr; we_data = m_wdata;
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    x = sb_q.pop_front();
                    check({x.tag, "_err"}, {31'b0, err}, {31'b0, x.err});
                    check({x.tag, "_latency"}, cnt, x.lat);
                    check({x.tag, "_we_cycles"}, we_cnt, x.we_cnt);
                    if (x.we_cnt > 0) begin
                        check({x.tag, "_we_cycle"}, we_cyc, x.we_cyc);
                        check({x.tag, "_m_addr"}, we_addr, x.maddr);
                        check({x.tag, "_m_wdata"}, we_data, x.mwdata);
                    end
                    if (x.chk_rd)
                        check({x.tag, "_rdata"}, rdata, x.rdata);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 50);
        if (busy)
            check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
        wait_idle();
        #1;
        wr = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[5'd21] = 32'h1234_80A7;    // byte address 0x54

        clrn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0;
        addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",    {31'b0, busy}, 32'd0);
        check("rst_done",    {31'b0, done}, 32'd0);
        check("rst_err",     {31'b0, err},  32'd0);
        check("rst_m_we",    {31'b0, m_we}, 32'd0);
        check("rst_rdata",   rdata,   32'h0);
        check("rst_m_addr",  m_addr,  32'h0);
        check("rst_m_wdata", m_wdata, 32'h0);
        clrn = 1'b1;

        // Loads.
        sb_q.push_back(mk("lb_55", 0, 2, 0, 0, 0, 0, 1, 32'hFFFF_FF80));
        issue(1'b0, 2'b00, 1'b1, 32'h55, 32'h0);
        sb_q.push_back(mk("lbu_54", 0, 2, 0, 0, 0, 0, 1, 32'h0000_00A7));
        issue(1'b0, 2'b00, 1'b0, 32'h54, 32'h0);

        // Errors: rdata must keep the previous load result.
        sb_q.push_back(mk("lh_53_misal", 1, 1, 0, 0, 0, 0, 1, 32'h0000_00A7));
        issue(1'b0, 2'b01, 1'b1, 32'h53, 32'h0);
        sb_q.push_back(mk("size11", 1, 1, 0, 0, 0, 0, 1, 32'h0000_00A7));
        issue(1'b0, 2'b11, 1'b0, 32'h54, 32'h0);

        // Half store (read-modify-write), then read back.
        sb_q.push_back(mk("sh_56", 0, 3, 1, 2, 32'h54, 32'hBEEF_80A7, 1, 32'h0000_00A7));
        issue(1'b1, 2'b01, 1'b0, 32'h56, 32'h0000_BEEF);
        sb_q.push_back(mk("lw_54", 0, 2, 0, 0, 0, 0, 1, 32'hBEEF_80A7));
        issue(1'b0, 2'b10, 1'b0, 32'h54, 32'h0);

        // Word store: write in the first cycle after accept.
        sb_q.push_back(mk("sw_60", 0, 2, 1, 1, 32'h60, 32'h0000_0258, 1, 32'hBEEF_80A7));
        issue(1'b1, 2'b10, 1'b0, 32'h60, 32'h0000_0258);
        wait_idle();
        check("mem_60", mem[5'd24], 32'h0000_0258);

        // More extension patterns on the merged word.
        sb_q.push_back(mk("lhu_56", 0, 2, 0, 0, 0, 0, 1, 32'h0000_BEEF));
        issue(1'b0, 2'b01, 1'b0, 32'h56, 32'h0);
        sb_q.push_back(mk("lh_56", 0, 2, 0, 0, 0, 0, 1, 32'hFFFF_BEEF));
        issue(1'b0, 2'b01, 1'b1, 32'h56, 32'h0);
        sb_q.push_back(mk("lb_57", 0, 2, 0, 0, 0, 0, 1, 32'hFFFF_FFBE));
        issue(1'b0, 2'b00, 1'b1, 32'h57, 32'h0);

        // Reset in the WR cycle of a byte store. No done is expected.
        issue(1'b1, 2'b00, 1'b0, 32'h54, 32'h0000_0011);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_we && n < 10);
        check("sb_we_seen", {31'b0, m_we}, 32'd1);
        #1 clrn = 1'b0;
        #1;
        check("arst_m_we",    {31'b0, m_we}, 32'd0);
        check("arst_busy",    {31'b0, busy}, 32'd0);
        check("arst_done",    {31'b0, done}, 32'd0);
        check("arst_err",     {31'b0, err},  32'd0);
        check("arst_rdata",   rdata,   32'h0);
        check("arst_m_addr",  m_addr,  32'h0);
        check("arst_m_wdata", m_wdata, 32'h0);
        @(posedge clk);
        #1 check("arst_mem_54", mem[5'd21], 32'hBEEF_80A7);

        // Back-to-back loads with req held high across reset release.
        wr = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h54; req = 1'b1;
        sb_q.push_back(mk("b2b_lw_54", 0, 2, 0, 0, 0, 0, 1, 32'hBEEF_80A7));
        sb_q.push_back(mk("b2b_lw_60", 0, 2, 0, 0, 0, 0, 1, 32'h0000_0258));
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;
        check("accept_after_reset", {31'b0, busy}, 32'd1);
        addr = 32'h60;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 10);
        check("b2b_idle_gap", n, 32'd3);
        @(posedge clk);
        #1;
        check("b2b_second_accept", {31'b0, busy}, 32'd1);
        req = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
